// File: rtl/rom_loader_dma.sv
// Packs the loader byte stream into big-endian SDRAM words, queues them in a small FIFO and
// issues them over a toggle-handshake port; releases the core once the last write is acknowledged.
module rom_loader_dma #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W = 25,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ROM_BASE = '0,
  parameter logic [ADDR_W-1:0] SAVE_BASE = ADDR_W'(25'h0820000),
  localparam int LW = $clog2(WORD_BYTES),
  localparam int DW = 8 * WORD_BYTES,
  localparam int AW = ADDR_W - LW
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [2:0]            loading,
  input  logic [7:0]            loader_do,
  input  logic                  loader_do_valid,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic [WORD_BYTES-1:0] mem_be,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  core_on,
  output logic [ADDR_W-1:0]     rom_size,
  output logic [ADDR_W-1:0]     save_size,
  output logic                  overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t                r_state;
  logic [2:0]            r_mode;
  logic [ADDR_W-1:0]     r_base;
  logic [ADDR_W-1:0]     r_count;
  logic [DW-1:0]         r_word;
  logic [WORD_BYTES-1:0] r_be;

  logic                  r_stgValid;
  logic [AW-1:0]         r_stgAddr;
  logic [DW-1:0]         r_stgWord;
  logic [WORD_BYTES-1:0] r_stgBe;

  logic [AW-1:0]         r_fifoAddr [FIFO_DEPTH];
  logic [DW-1:0]         r_fifoData [FIFO_DEPTH];
  logic [WORD_BYTES-1:0] r_fifoBe   [FIFO_DEPTH];
  logic [PW:0]           r_wrPtr;
  logic [PW:0]           r_rdPtr;

  logic                  r_memReq;
  logic [AW-1:0]         r_memAddr;
  logic [DW-1:0]         r_memData;
  logic [WORD_BYTES-1:0] r_memBe;
  logic                  r_coreOn;
  logic [ADDR_W-1:0]     r_romSize;
  logic [ADDR_W-1:0]     r_saveSize;
  logic                  r_overflow;

  logic                  w_newLoad;
  logic                  w_leaveLoad;
  logic                  w_accept;
  logic                  w_take;
  logic                  w_cntMax;
  logic                  w_packRegion;
  logic                  w_complete;
  logic                  w_flush;
  logic [2:0]            w_curMode;
  logic [ADDR_W-1:0]     w_newBase;
  logic [ADDR_W-1:0]     w_curBase;
  logic [ADDR_W-1:0]     w_curCnt;
  logic [ADDR_W-1:0]     w_laneBits;
  logic [ADDR_W-1:0]     w_byteAddr;
  logic [ADDR_W-1:0]     w_flushAddr;
  logic [DW-1:0]         w_packWord;
  logic [WORD_BYTES-1:0] w_packBe;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_portIdle;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // A byte on the same cycle as a loading change belongs to the new region, so the
  // packing context (mode, base, count, partial word) switches to a fresh one here.
  always_comb begin
    w_newBase = '0;
    if (loading == 3'd1) w_newBase = ROM_BASE;
    else if (loading == 3'd2) w_newBase = SAVE_BASE;

    w_newLoad   = (loading != 3'd0) && ((r_state != S_LOAD) || (loading != r_mode));
    w_leaveLoad = (r_state == S_LOAD) && (loading != r_mode);
    w_curMode   = w_newLoad ? loading : r_mode;
    w_curBase   = w_newLoad ? w_newBase : r_base;
    w_curCnt    = w_newLoad ? '0 : r_count;
    w_packWord  = w_newLoad ? '0 : r_word;
    w_packBe    = w_newLoad ? '0 : r_be;
    w_laneBits  = w_curCnt & LANE_MASK;

    for (int k = 0; k < WORD_BYTES; k++) begin
      if (w_laneBits == ADDR_W'(k)) begin
        w_packWord[8*(WORD_BYTES-k)-1 -: 8] = loader_do;
        w_packBe[WORD_BYTES-1-k] = 1'b1;
      end
    end

    w_accept     = loader_do_valid && (loading != 3'd0);
    w_cntMax     = &w_curCnt;
    w_take       = w_accept && !w_cntMax;
    w_packRegion = (w_curMode == 3'd1) || (w_curMode == 3'd2);
    w_complete   = w_take && w_packRegion && (w_laneBits == LANE_MASK);
    w_flush      = w_leaveLoad && (r_be != '0);
    w_byteAddr   = w_curBase + w_curCnt;
    w_flushAddr  = r_base + r_count;
  end

  // A pop frees a slot in the same cycle, so push-with-pop on a full FIFO is not a drop.
  always_comb begin
    w_empty    = (r_wrPtr == r_rdPtr);
    w_full     = (r_wrPtr[PW] != r_rdPtr[PW]) && (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]);
    w_portIdle = (r_memReq == mem_ack);
    w_pop      = w_portIdle && !w_empty;
    w_push     = r_stgValid && (!w_full || w_pop);
    w_drop     = r_stgValid && w_full && !w_pop;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_base     <= '0;
      r_count    <= '0;
      r_word     <= '0;
      r_be       <= '0;
      r_stgValid <= 1'b0;
      r_stgAddr  <= '0;
      r_stgWord  <= '0;
      r_stgBe    <= '0;
      r_coreOn   <= 1'b0;
      r_romSize  <= '0;
      r_saveSize <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_stgValid <= w_complete || w_flush;
      if (w_complete) begin
        r_stgAddr <= AW'(w_byteAddr >> LW);
        r_stgWord <= w_packWord;
        r_stgBe   <= w_packBe;
      end else if (w_flush) begin
        r_stgAddr <= AW'(w_flushAddr >> LW);
        r_stgWord <= r_word;
        r_stgBe   <= r_be;
      end

      if (w_take && w_packRegion) begin
        r_word <= w_complete ? '0 : w_packWord;
        r_be   <= w_complete ? '0 : w_packBe;
      end else if (w_leaveLoad) begin
        r_word <= '0;
        r_be   <= '0;
      end

      if (w_take) r_count <= w_curCnt + ADDR_W'(1);
      else if (w_newLoad) r_count <= '0;

      case (r_state)
        S_IDLE, S_DRAIN: begin
          if (w_newLoad) begin
            r_state    <= S_LOAD;
            r_mode     <= loading;
            r_base     <= w_newBase;
            r_coreOn   <= 1'b0;
            r_overflow <= 1'b0;
          end else if ((r_state == S_DRAIN) && w_empty && !r_stgValid && w_portIdle) begin
            r_state  <= S_IDLE;
            r_coreOn <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_leaveLoad) begin
            if (r_mode == 3'd1) r_romSize <= r_count;
            else if (r_mode == 3'd2) r_saveSize <= r_count;
            if (loading == 3'd0) begin
              r_state <= S_DRAIN;
            end else begin
              r_mode <= loading;
              r_base <= w_newBase;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_drop || (w_accept && w_cntMax)) r_overflow <= 1'b1;
    end
  end

  // The SDRAM side is not reset with us, so the request toggle resyncs to the ack level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_memReq  <= mem_ack;
      r_memAddr <= '0;
      r_memData <= '0;
      r_memBe   <= '0;
    end else begin
      if (w_push) begin
        r_fifoAddr[r_wrPtr[PW-1:0]] <= r_stgAddr;
        r_fifoData[r_wrPtr[PW-1:0]] <= r_stgWord;
        r_fifoBe[r_wrPtr[PW-1:0]]   <= r_stgBe;
        r_wrPtr <= r_wrPtr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_memAddr <= r_fifoAddr[r_rdPtr[PW-1:0]];
        r_memData <= r_fifoData[r_rdPtr[PW-1:0]];
        r_memBe   <= r_fifoBe[r_rdPtr[PW-1:0]];
        r_rdPtr   <= r_rdPtr + (PW+1)'(1);
        r_memReq  <= ~r_memReq;
      end
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memData;
  assign mem_be    = r_memBe;
  assign mem_req   = r_memReq;
  assign core_on   = r_coreOn;
  assign rom_size  = r_romSize;
  assign save_size = r_saveSize;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rom_loader_dma.sv
// Bench for rom_loader_dma: table-driven loads plus hand sequences, with an SDRAM responder
// that checks every issued write against a queue of words predicted from the byte stream.
module tb_rom_loader_dma;

  logic        clk_sys;
  logic        reset;
  logic [2:0]  loading;
  logic [7:0]  loader_do;
  logic        loader_do_valid;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_req;
  logic        mem_ack;
  logic        core_on;
  logic [24:0] rom_size;
  logic [24:0] save_size;
  logic        overflow;

  rom_loader_dma #(
    .WORD_BYTES(2),
    .ADDR_W(25),
    .FIFO_DEPTH(4),
    .ROM_BASE(25'h0000000),
    .SAVE_BASE(25'h0820000)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .loading(loading),
    .loader_do(loader_do),
    .loader_do_valid(loader_do_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .core_on(core_on),
    .rom_size(rom_size),
    .save_size(save_size),
    .overflow(overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } wr_t;

  typedef struct {
    logic [2:0] mode;
    int         nBytes;
    logic [7:0] seed;
    int         ackDelay;
    int         gap;
    int         expRom;
    int         expSave;
    logic       expOvf;
  } vec_t;

  wr_t sbQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  ackDelay = 0;
  bit  ackHold = 0;
  bit  ackForce = 0;
  int  reqSeen = 0;

  logic [2:0]  prevLd = 3'd0;
  logic [2:0]  mMode = 3'd0;
  logic [24:0] mBase = '0;
  int          mCount = 0;
  logic [23:0] mAddr = '0;
  logic [15:0] mWord = '0;
  logic [1:0]  mBe = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelStart(input logic [2:0] mode);
    mMode  = mode;
    mCount = 0;
    mWord  = '0;
    mBe    = '0;
    mBase  = (mode == 3'd1) ? 25'h0000000 : (mode == 3'd2) ? 25'h0820000 : 25'h0;
  endtask

  task automatic modelPush();
    wr_t w;
    w.addr  = mAddr;
    w.wdata = mWord;
    w.be    = mBe;
    sbQ.push_back(w);
    mWord = '0;
    mBe   = '0;
  endtask

  // First byte of a word goes to the high byte and fixes the word address.
  task automatic modelByte(input logic [7:0] b);
    if (mMode == 3'd1 || mMode == 3'd2) begin
      if (mCount % 2 == 0) begin
        mAddr = 24'((mBase + 25'(mCount)) >> 1);
        mWord[15:8] = b;
        mBe[1] = 1'b1;
      end else begin
        mWord[7:0] = b;
        mBe[0] = 1'b1;
        modelPush();
      end
    end
    mCount++;
  endtask

  task automatic applyStimulus(input logic [2:0] ld, input logic v, input logic [7:0] b);
    if (ld != prevLd) begin
      if (prevLd != 3'd0 && mBe != 2'b00) modelPush();
      if (ld != 3'd0) modelStart(ld);
      prevLd = ld;
    end
    if (v && ld != 3'd0) modelByte(b);
    loading = ld;
    loader_do_valid = v;
    loader_do = b;
    @(negedge clk_sys);
  endtask

  task automatic waitCoreOn(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (core_on === 1'b1) break;
      @(negedge clk_sys);
    end
  endtask

  task automatic runRow(input int r, input vec_t v);
    ackDelay = v.ackDelay;
    for (int i = 0; i < v.nBytes; i++) begin
      applyStimulus(v.mode, 1'b1, v.seed + 8'(i * 17));
      for (int g = 0; g < v.gap; g++) applyStimulus(v.mode, 1'b0, 8'h00);
    end
    if (v.nBytes == 0) applyStimulus(v.mode, 1'b0, 8'h00);
    applyStimulus(3'd0, 1'b0, 8'h00);
    waitCoreOn(400);
    checkOutput($sformatf("row%0d_core_on", r), 32'(core_on), 32'd1);
    checkOutput($sformatf("row%0d_rom_size", r), 32'(rom_size), 32'(v.expRom));
    checkOutput($sformatf("row%0d_save_size", r), 32'(save_size), 32'(v.expSave));
    checkOutput($sformatf("row%0d_overflow", r), 32'(overflow), 32'(v.expOvf));
    checkOutput($sformatf("row%0d_writes_left", r), 32'(sbQ.size()), 32'd0);
  endtask

  // SDRAM model: one request at a time, acknowledged after ackDelay cycles unless held.
  initial begin
    bit  busy;
    int  cnt;
    wr_t e;
    logic [15:0] mask;
    busy = 0;
    cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ackForce) begin
        mem_ack = 1'b1;
        busy = 0;
      end else begin
        if (!busy && mem_req !== mem_ack) begin
          reqSeen++;
          if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
          end else begin
            e = sbQ.pop_front();
            mask = {{8{e.be[1]}}, {8{e.be[0]}}};
            checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
            checkOutput("wr_be", 32'(mem_be), 32'(e.be));
            checkOutput("wr_wdata", 32'(mem_wdata & mask), 32'(e.wdata & mask));
          end
          busy = 1;
          cnt = ackDelay;
        end
        if (busy && !ackHold) begin
          if (cnt == 0) begin
            mem_ack = mem_req;
            busy = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    vec_t post;
    int   base;
    int   toggles;
    logic last;

    vecs[0] = '{3'd1, 3,  8'h11, 0,  0, 3,  0, 1'b0};
    vecs[1] = '{3'd2, 4,  8'hAA, 2,  0, 3,  4, 1'b0};
    vecs[2] = '{3'd1, 0,  8'h00, 0,  0, 0,  4, 1'b0};
    vecs[3] = '{3'd5, 6,  8'h01, 0,  0, 0,  4, 1'b0};
    vecs[4] = '{3'd1, 10, 8'h10, 20, 0, 10, 4, 1'b0};
    vecs[5] = '{3'd2, 7,  8'h33, 1,  1, 10, 7, 1'b0};
    post    = '{3'd1, 2,  8'h7E, 3,  0, 2,  0, 1'b0};

    reset = 1'b1;
    loading = 3'd0;
    loader_do = 8'h00;
    loader_do_valid = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_core_on", 32'(core_on), 32'd0);
    checkOutput("rst_rom_size", 32'(rom_size), 32'd0);
    checkOutput("rst_save_size", 32'(save_size), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    for (int r = 0; r < 6; r++) runRow(r, vecs[r]);

    // ROM -> save switch after 5 bytes; the first save byte rides the switching cycle.
    ackDelay = 1;
    for (int i = 0; i < 5; i++) applyStimulus(3'd1, 1'b1, 8'h50 + 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(3'd2, 1'b1, 8'h60 + 8'(i));
    applyStimulus(3'd0, 1'b0, 8'h00);
    waitCoreOn(400);
    checkOutput("switch_core_on", 32'(core_on), 32'd1);
    checkOutput("switch_rom_size", 32'(rom_size), 32'd5);
    checkOutput("switch_save_size", 32'(save_size), 32'd3);
    checkOutput("switch_writes_left", 32'(sbQ.size()), 32'd0);

    // Ack never comes: one write issued, four queued, the sixth word is dropped.
    ackHold = 1;
    base = reqSeen;
    for (int i = 0; i < 12; i++) applyStimulus(3'd1, 1'b1, 8'hC0 + 8'(i));
    applyStimulus(3'd0, 1'b0, 8'h00);
    repeat (40) @(negedge clk_sys);
    checkOutput("hold_overflow", 32'(overflow), 32'd1);
    checkOutput("hold_core_on", 32'(core_on), 32'd0);
    checkOutput("hold_requests", 32'(reqSeen - base), 32'd1);
    checkOutput("hold_rom_size", 32'(rom_size), 32'd12);

    // Reset with words still queued while the SDRAM side reports ack=1.
    reset = 1'b1;
    ackForce = 1;
    repeat (3) @(negedge clk_sys);
    checkOutput("rstmid_mem_req", 32'(mem_req), 32'd1);
    checkOutput("rstmid_core_on", 32'(core_on), 32'd0);
    reset = 1'b0;
    toggles = 0;
    last = mem_req;
    repeat (10) begin
      @(negedge clk_sys);
      if (mem_req !== last) toggles++;
      last = mem_req;
    end
    checkOutput("rstmid_toggles", 32'(toggles), 32'd0);
    checkOutput("rstmid_req_held", 32'(mem_req), 32'd1);
    checkOutput("rstmid_core_on_after", 32'(core_on), 32'd0);
    checkOutput("rstmid_overflow", 32'(overflow), 32'd0);
    checkOutput("rstmid_rom_size", 32'(rom_size), 32'd0);
    checkOutput("rstmid_mem_be", 32'(mem_be), 32'd0);
    sbQ.delete();
    ackForce = 0;
    ackHold = 0;
    @(negedge clk_sys);

    runRow(6, post);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
